reg_write_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 5-bit storage register (clk/rst/en/d style) among N_REQ requesters.
- Accepts write requests, selects one winner fairly, and captures the winner's data.
- Drives the register's enable and data for exactly one cycle, then returns a one-cycle acknowledge to the winner.
- Sits between requesting control units and the shared register.

---
 rtl/reg_write_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter/sequencer for one shared register
// Optional requester lock bursts are enabled with `define ARB_LOCK_EN.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [N_REQ-1:0]       lock,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_d,
  output logic [N_REQ-1:0]       ack,
  output logic [IDW-1:0]         gnt_id,
  output logic                   busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [WIDTH-1:0] pick_data;
  int               idx;

`ifdef ARB_LOCK_EN
  logic             lock_flag_q, lock_flag_d;
  logic [1:0]       burst_q, burst_d;
  logic [WIDTH-1:0] own_data;
`else
  logic             unused_lock;
  assign unused_lock = ^lock;
`endif

  // First asserted request scanning upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_data = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick      = IDW'(idx);
        pick_data = wdata[idx*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_comb begin
    own_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == gnt_id_q) own_data = wdata[k*WIDTH +: WIDTH];
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cap_data_d = cap_data_q;
    gnt_id_d   = gnt_id_q;
    reg_en_d   = 1'b0;
    reg_d_d    = reg_d_q;
    ack_d      = '0;
    busy_d     = 1'b0;
`ifdef ARB_LOCK_EN
    lock_flag_d = lock_flag_q;
    burst_d     = burst_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (lock_flag_q) begin
          // Locked re-grant: same winner, fresh data, rr_ptr untouched.
          cap_data_d  = own_data;
          reg_d_d     = own_data;
          reg_en_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = GRANT;
          lock_flag_d = 1'b0;
          burst_d     = burst_q + 2'd1;
        end else
`endif
        if (found) begin
          gnt_id_d   = pick;
          cap_data_d = pick_data;
          reg_d_d    = pick_data;
          reg_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = GRANT;
`ifdef ARB_LOCK_EN
          burst_d    = 2'd0;
`endif
        end
      end
      GRANT: begin
        state_d = ACK;
        busy_d  = 1'b1;
        ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
        if (gnt_id_q == IDW'(N_REQ-1)) rr_ptr_d = '0;
        else                           rr_ptr_d = gnt_id_q + 1'b1;
      end
      ACK: begin
        state_d = IDLE;
`ifdef ARB_LOCK_EN
        if (lock[gnt_id_q] && req[gnt_id_q] && (burst_q != 2'd3)) lock_flag_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cap_data_q <= '0;
      gnt_id_q   <= '0;
      reg_en_q   <= 1'b0;
      reg_d_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_flag_q <= 1'b0;
      burst_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cap_data_q <= cap_data_d;
      gnt_id_q   <= gnt_id_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef ARB_LOCK_EN
      lock_flag_q <= lock_flag_d;
      burst_q     <= burst_d;
`endif
    end
  end

  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign ack    = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
